// File: rtl/lzrw1_pkg.sv
// rtl/lzrw1_pkg.sv - shared LZRW1 token and packer types plus the default block size
// Purpose: types shared by the packer, compressor and decompressor tops.
// Ports: none (package).
package lzrw1_pkg;

    // Byte capacity of one compressed block.
    localparam int DEFAULT_STRINGSIZE = 128;

    typedef enum logic {
        TOK_LITERAL = 1'b0,
        TOK_COPY    = 1'b1
    } lzrw1_tok_e;

    typedef enum logic [1:0] {
        PK_IDLE = 2'd0,
        PK_PACK = 2'd1,
        PK_DONE = 2'd2
    } packer_state_e;

endpackage

// File: rtl/lzrw1_token_packer_if.sv
// rtl/lzrw1_token_packer_if.sv - token handshake between match engine and packer
// Purpose: carries one literal/copy token per accepted handshake.
// Ports (signals):
//   tok_valid - token present (master)
//   tok_ctrl  - 0 literal, 1 copy (master)
//   tok_data  - literal byte in [7:0]; copy bytes [15:8] then [7:0] (master)
//   tok_ready - packer can take the presented token (slave)
interface lzrw1_token_packer_if;
    logic        tok_valid;
    logic        tok_ready;
    logic        tok_ctrl;
    logic [15:0] tok_data;

    modport master (output tok_valid, output tok_ctrl, output tok_data, input tok_ready);
    modport slave  (input tok_valid, input tok_ctrl, input tok_data, output tok_ready);
endinterface

// File: rtl/lzrw1_token_packer.sv
// rtl/lzrw1_token_packer.sv - packs LZRW1 literal/copy tokens into a compressed block
// Purpose: writer side of the LZRW1 block format; one byte per literal, two per copy,
//          one control bit per token.
// Ports:
//   clock, reset     - single clock, asynchronous active-low reset
//   tok              - token handshake (slave side)
//   start            - open a new block, clearing everything
//   flush            - close the current block
//   compArray        - packed bytes, byte i at [i]
//   controlWord      - bit i = kind of token i
//   controlPtr       - tokens stored
//   dataPtr          - bytes stored
//   Done             - block closed, outputs frozen
//   block_full       - block closed because the presented token did not fit
module lzrw1_token_packer
    import lzrw1_pkg::*;
#(
    parameter int  STRINGSIZE = DEFAULT_STRINGSIZE,
    localparam int PTR_W      = $clog2(STRINGSIZE + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    lzrw1_token_packer_if.slave         tok,
    input  logic                        start,
    input  logic                        flush,
    output logic [STRINGSIZE-1:0][7:0]  compArray,
    output logic [STRINGSIZE-1:0]       controlWord,
    output logic [PTR_W-1:0]            controlPtr,
    output logic [PTR_W-1:0]            dataPtr,
    output logic                        Done,
    output logic                        block_full
);

    packer_state_e               state_q, state_d;
    logic [STRINGSIZE-1:0][7:0]  comp_q, comp_d;
    logic [STRINGSIZE-1:0]       ctrl_q, ctrl_d;
    logic [PTR_W-1:0]            cptr_q, cptr_d;
    logic [PTR_W-1:0]            dptr_q, dptr_d;
    logic [PTR_W-1:0]            dptr_nxt1;
    logic                        full_q, full_d;
    logic                        is_copy, room, live, accept, stall;

    assign is_copy   = (lzrw1_tok_e'(tok.tok_ctrl) == TOK_COPY);
    assign dptr_nxt1 = dptr_q + PTR_W'(1);

    // Packing is only possible when no block-level command competes this cycle.
    assign live = (state_q == PK_PACK) && !start && !flush;

    // Room depends on the presented token's size, never on tok_valid.
    always_comb begin
        room = 1'b0;
        if (cptr_q < PTR_W'(STRINGSIZE)) begin
            room = is_copy ? (dptr_q <= PTR_W'(STRINGSIZE - 2))
                           : (dptr_q <= PTR_W'(STRINGSIZE - 1));
        end
    end

    assign accept = live && room && tok.tok_valid;
    // A token that does not fit closes the block and is left on the interface.
    assign stall  = live && !room && tok.tok_valid;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= PK_IDLE;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
        end
    end

    // Next state; flush takes priority over the full condition.
    always_comb begin
        state_d = state_q;
        full_d  = full_q;
        if (start) begin
            state_d = PK_PACK;
            full_d  = 1'b0;
        end else if (state_q == PK_PACK) begin
            if (flush) begin
                state_d = PK_DONE;
            end else if (stall) begin
                state_d = PK_DONE;
                full_d  = 1'b1;
            end
        end
    end

    // FSM outputs
    always_comb begin
        Done       = (state_q == PK_DONE);
        block_full = full_q;
    end
    assign tok.tok_ready = live && room;

    // Block contents: byte/bit write decode for the accepted token.
    always_comb begin
        comp_d = comp_q;
        ctrl_d = ctrl_q;
        cptr_d = cptr_q;
        dptr_d = dptr_q;
        if (start) begin
            comp_d = '0;
            ctrl_d = '0;
            cptr_d = '0;
            dptr_d = '0;
        end else if (accept) begin
            for (int i = 0; i < STRINGSIZE; i++) begin
                if (dptr_q == PTR_W'(i)) begin
                    comp_d[i] = is_copy ? tok.tok_data[15:8] : tok.tok_data[7:0];
                end
                if (is_copy && (dptr_nxt1 == PTR_W'(i))) begin
                    comp_d[i] = tok.tok_data[7:0];
                end
                if (cptr_q == PTR_W'(i)) begin
                    ctrl_d[i] = is_copy;
                end
            end
            cptr_d = cptr_q + PTR_W'(1);
            dptr_d = is_copy ? (dptr_q + PTR_W'(2)) : dptr_nxt1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            comp_q <= '0;
            ctrl_q <= '0;
            cptr_q <= '0;
            dptr_q <= '0;
        end else begin
            comp_q <= comp_d;
            ctrl_q <= ctrl_d;
            cptr_q <= cptr_d;
            dptr_q <= dptr_d;
        end
    end

    assign compArray   = comp_q;
    assign controlWord = ctrl_q;
    assign controlPtr  = cptr_q;
    assign dataPtr     = dptr_q;

endmodule
